// File: rtl/ifetch_buf_pkg.sv
// -----------------------------------------------------------------------------
// ifetch_buf_pkg
//   Shared definitions for the instruction prefetch queue: bus widths, the
//   NOP encoding presented when the queue is empty, the zero word, and the
//   packed {inst, addr} entry stored per queue slot.
// -----------------------------------------------------------------------------
package ifetch_buf_pkg;

   localparam int InstBus     = 32;
   localparam int InstAddrBus = 32;

   // addi x0, x0, 0 -- harmless filler for the decode stage
   localparam logic [InstBus-1:0]     INST_NOP = 32'h0000_0013;
   localparam logic [InstAddrBus-1:0] ZeroWord = 32'h0000_0000;

   typedef struct packed {
      logic [InstBus-1:0]     inst;
      logic [InstAddrBus-1:0] addr;
   } entry_t;

   localparam entry_t ENTRY_ZERO = '{inst: '0, addr: ZeroWord};

endpackage : ifetch_buf_pkg

// File: rtl/ifetch_buf_mem.sv
// -----------------------------------------------------------------------------
// ifetch_buf_mem
//   DEPTH-entry register array, one synchronous write port and one
//   asynchronous read port. Word = {inst, addr}.
// Ports:
//   clk, rstn      clock, asynchronous active-low reset (clears all entries)
//   we_i           write enable
//   waddr_i        write slot
//   wdata_i        entry to write
//   raddr_i        read slot
//   rdata_o        entry at raddr_i (combinational)
// -----------------------------------------------------------------------------
module ifetch_buf_mem
   import ifetch_buf_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  entry_t        wdata_i,
   input  logic [AW-1:0] raddr_i,
   output entry_t        rdata_o
);

   entry_t mem_q [DEPTH];
   entry_t mem_d [DEPTH];

   always_comb begin
      mem_d = mem_q;
      if (we_i) begin
         mem_d[waddr_i] = wdata_i;
      end
   end

   // NOTE: the array sits in the reset domain on purpose -- entries must read
   // back as zero after reset, so this stays flops rather than a RAM macro.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= ENTRY_ZERO;
         end
      end else begin
         mem_q <= mem_d;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule : ifetch_buf_mem

// File: rtl/ifetch_buf.sv
// -----------------------------------------------------------------------------
// ifetch_buf
//   Instruction prefetch queue between fetch (pc + rom) and the if_id
//   register. Fetch keeps pushing {inst, addr} pairs while decode stalls;
//   decode pops in order. A flush (jump redirect / prediction failure) empties
//   the queue so no wrong-path instruction reaches decode.
// Ports:
//   clk, rstn             clock, asynchronous active-low reset
//   flush_i               discard all entries, clear overflow flag
//   push_i, inst_i,
//   instaddr_i            fetch side entry
//   full_o                no free entry; fetch holds pc
//   pop_i                 decode consumes head entry
//   valid_o, inst_o,
//   instaddr_o            head entry (NOP / 0 when empty)
//   count_o               occupancy 0..DEPTH
//   ovf_o                 sticky: a push was dropped
// -----------------------------------------------------------------------------
module ifetch_buf
   import ifetch_buf_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   flush_i,
   input  logic                   push_i,
   input  logic [InstBus-1:0]     inst_i,
   input  logic [InstAddrBus-1:0] instaddr_i,
   output logic                   full_o,
   input  logic                   pop_i,
   output logic                   valid_o,
   output logic [InstBus-1:0]     inst_o,
   output logic [InstAddrBus-1:0] instaddr_o,
   output logic [AW:0]            count_o,
   output logic                   ovf_o
);

   localparam int CW = AW + 1;

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q,  count_d;
   logic          ovf_q,    ovf_d;

   logic   push_acc;
   logic   pop_acc;
   entry_t head;
   entry_t wr_entry;

   assign valid_o = (count_q != '0);
   assign full_o  = (count_q == CW'(DEPTH));

   // A pop frees a slot in the same cycle, so a full queue may still accept.
   assign pop_acc  = pop_i && valid_o && !flush_i;
   assign push_acc = push_i && (!full_o || pop_acc) && !flush_i;

   assign wr_entry = '{inst: inst_i, addr: instaddr_i};

   // NOTE: every always_comb output gets a default first, so no path through
   // the block leaves a value unassigned and no latch is inferred.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;

      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         ovf_d    = 1'b0;
      end else begin
         if (push_acc) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop_acc)  rd_ptr_d = rd_ptr_q + AW'(1);
         count_d = count_q + CW'(push_acc) - CW'(pop_acc);
         if (push_i && !push_acc) ovf_d = 1'b1;
      end
   end

   // NOTE: state flops use non-blocking assignments so all of them sample
   // the same pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   ifetch_buf_mem #(
      .DEPTH (DEPTH)
   ) u_mem (
      .clk     (clk),
      .rstn    (rstn),
      .we_i    (push_acc),
      .waddr_i (wr_ptr_q),
      .wdata_i (wr_entry),
      .raddr_i (rd_ptr_q),
      .rdata_o (head)
   );

   // No bypass: the head is always read from storage, never from inst_i.
   assign inst_o     = valid_o ? head.inst : INST_NOP;
   assign instaddr_o = valid_o ? head.addr : ZeroWord;
   assign count_o    = count_q;
   assign ovf_o      = ovf_q;

endmodule : ifetch_buf

// File: tb/tb_ifetch_buf.sv
// -----------------------------------------------------------------------------
// tb_ifetch_buf
//   Self-checking bench for ifetch_buf (DEPTH = 4): directed vector table,
//   hand sequences for reset, and randomized traffic against a queue model.
// -----------------------------------------------------------------------------
module tb_ifetch_buf;

   localparam int          DEPTH = 4;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rstn;
   logic        flush_i, push_i, pop_i;
   logic [31:0] inst_i, instaddr_i;
   logic        full_o, valid_o, ovf_o;
   logic [31:0] inst_o, instaddr_o;
   logic [2:0]  count_o;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   ifetch_buf #(.DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .flush_i    (flush_i),
      .push_i     (push_i),
      .inst_i     (inst_i),
      .instaddr_i (instaddr_i),
      .full_o     (full_o),
      .pop_i      (pop_i),
      .valid_o    (valid_o),
      .inst_o     (inst_o),
      .instaddr_o (instaddr_o),
      .count_o    (count_o),
      .ovf_o      (ovf_o)
   );

   // ---------------- reference model: plain queue ----------------
   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] addr;
   } ent_t;

   ent_t m_q[$];
   bit   m_ovf;

   function automatic void model_step(bit push, bit pop, bit flush,
                                      logic [31:0] inst, logic [31:0] addr);
      bit pop_ok, push_ok;
      if (flush) begin
         m_q.delete();
         m_ovf = 1'b0;
         return;
      end
      pop_ok  = pop && (m_q.size() > 0);
      push_ok = push && ((m_q.size() < DEPTH) || pop_ok);
      if (pop_ok) void'(m_q.pop_front());
      if (push_ok) m_q.push_back('{inst: inst, addr: addr});
      else if (push) m_ovf = 1'b1;
   endfunction

   // {valid, full, count, ovf, inst, addr}
   function automatic logic [69:0] model_out();
      logic [31:0] ei, ea;
      ei = (m_q.size() > 0) ? m_q[0].inst : NOP;
      ea = (m_q.size() > 0) ? m_q[0].addr : 32'h0;
      return {m_q.size() > 0, m_q.size() == DEPTH, 3'(m_q.size()), m_ovf, ei, ea};
   endfunction

   function automatic logic [69:0] dut_out();
      return {valid_o, full_o, count_o, ovf_o, inst_o, instaddr_o};
   endfunction

   task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got v=%b f=%b cnt=%0d ovf=%b inst=%h addr=%h, want v=%b f=%b cnt=%0d ovf=%b inst=%h addr=%h",
                  name, act[69], act[68], act[67:65], act[64], act[63:32], act[31:0],
                  exp[69], exp[68], exp[67:65], exp[64], exp[63:32], exp[31:0]);
      end
   endtask

   // Drive one cycle of inputs, clock it, step the model, settle #1.
   task automatic apply(input bit push, input bit pop, input bit flush,
                        input logic [31:0] inst, input logic [31:0] addr);
      push_i = push; pop_i = pop; flush_i = flush;
      inst_i = inst; instaddr_i = addr;
      @(posedge clk);
      model_step(push, pop, flush, inst, addr);
      #1;
      push_i = 1'b0; pop_i = 1'b0; flush_i = 1'b0;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      bit          push, pop, flush;
      logic [31:0] addr, inst;
      int          e_cnt;
      bit          e_valid, e_full, e_ovf;
      logic [31:0] e_addr, e_inst;
   } vec_t;

   vec_t tbl[$];

   function automatic void row(bit pu, bit po, bit fl, logic [31:0] a, logic [31:0] i,
                               int c, bit v, bit f, bit o, logic [31:0] ea, logic [31:0] ei);
      vec_t r;
      r.push = pu; r.pop = po; r.flush = fl; r.addr = a; r.inst = i;
      r.e_cnt = c; r.e_valid = v; r.e_full = f; r.e_ovf = o; r.e_addr = ea; r.e_inst = ei;
      tbl.push_back(r);
   endfunction

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      logic [69:0] exp;
      rstn = 1'b0; flush_i = 1'b0; pop_i = 1'b0;
      push_i = 1'b1; inst_i = 32'hDEAD_BEEF; instaddr_i = 32'h0000_1000;

      // Reset held with push asserted: nothing may enter.
      repeat (3) @(posedge clk);
      #1;
      check("reset_hold", dut_out(), {1'b0, 1'b0, 3'd0, 1'b0, NOP, 32'h0});
      push_i = 1'b0;
      #2 rstn = 1'b1;
      #1;
      check("reset_release", dut_out(), {1'b0, 1'b0, 3'd0, 1'b0, NOP, 32'h0});

      //  push pop flush addr   inst    cnt v f o  e_addr  e_inst
      // fill, overflow, drain
      row(1,0,0, 32'h00, 32'h11,  1,1,0,0, 32'h00, 32'h11);
      row(1,0,0, 32'h04, 32'h12,  2,1,0,0, 32'h00, 32'h11);
      row(1,0,0, 32'h08, 32'h13,  3,1,0,0, 32'h00, 32'h11);
      row(1,0,0, 32'h0C, 32'h14,  4,1,1,0, 32'h00, 32'h11);
      row(1,0,0, 32'h10, 32'h15,  4,1,1,1, 32'h00, 32'h11);
      row(0,1,0, 32'h0,  32'h0,   3,1,0,1, 32'h04, 32'h12);
      row(0,1,0, 32'h0,  32'h0,   2,1,0,1, 32'h08, 32'h13);
      row(0,1,0, 32'h0,  32'h0,   1,1,0,1, 32'h0C, 32'h14);
      row(0,1,0, 32'h0,  32'h0,   0,0,0,1, 32'h0,  NOP);
      row(0,1,0, 32'h0,  32'h0,   0,0,0,1, 32'h0,  NOP);
      row(0,0,1, 32'h0,  32'h0,   0,0,0,0, 32'h0,  NOP);
      // full with simultaneous push and pop
      row(1,0,0, 32'h00, 32'h21,  1,1,0,0, 32'h00, 32'h21);
      row(1,0,0, 32'h04, 32'h22,  2,1,0,0, 32'h00, 32'h21);
      row(1,0,0, 32'h08, 32'h23,  3,1,0,0, 32'h00, 32'h21);
      row(1,0,0, 32'h0C, 32'h24,  4,1,1,0, 32'h00, 32'h21);
      row(1,1,0, 32'h10, 32'h25,  4,1,1,0, 32'h04, 32'h22);
      row(0,1,0, 32'h0,  32'h0,   3,1,0,0, 32'h08, 32'h23);
      row(0,1,0, 32'h0,  32'h0,   2,1,0,0, 32'h0C, 32'h24);
      row(0,1,0, 32'h0,  32'h0,   1,1,0,0, 32'h10, 32'h25);
      row(0,1,0, 32'h0,  32'h0,   0,0,0,0, 32'h0,  NOP);
      // empty with simultaneous push and pop
      row(1,1,0, 32'h20, 32'h31,  1,1,0,0, 32'h20, 32'h31);
      // flush with 3 entries, concurrent push and pop discarded
      row(1,0,0, 32'h24, 32'h32,  2,1,0,0, 32'h20, 32'h31);
      row(1,0,0, 32'h28, 32'h33,  3,1,0,0, 32'h20, 32'h31);
      row(1,1,1, 32'h40, 32'h34,  0,0,0,0, 32'h0,  NOP);
      row(1,0,0, 32'h80, 32'h35,  1,1,0,0, 32'h80, 32'h35);
      row(0,1,0, 32'h0,  32'h0,   0,0,0,0, 32'h0,  NOP);

      foreach (tbl[k]) begin
         apply(tbl[k].push, tbl[k].pop, tbl[k].flush, tbl[k].inst, tbl[k].addr);
         exp = {tbl[k].e_valid, tbl[k].e_full, 3'(tbl[k].e_cnt), tbl[k].e_ovf,
                tbl[k].e_inst, tbl[k].e_addr};
         check($sformatf("table[%0d]", k), dut_out(), exp);
      end

      // Wrap-around: interleaved traffic moves the pointers round twice.
      for (int i = 0; i < 10; i++) begin
         apply(1'b1, (i % 2) == 1, 1'b0, 32'h500 + 32'(i), 32'h100 + 32'(i * 4));
         check($sformatf("wrap[%0d]", i), dut_out(), model_out());
      end

      // Randomized traffic against the queue model.
      for (int i = 0; i < 300; i++) begin
         bit pu, po, fl;
         pu = ($urandom_range(0, 99) < 60);
         po = ($urandom_range(0, 99) < 45);
         fl = ($urandom_range(0, 99) < 4);
         apply(pu, po, fl, $urandom, $urandom);
         check($sformatf("rand[%0d]", i), dut_out(), model_out());
      end

      // Asynchronous reset between edges with 2 entries.
      apply(1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
      apply(1'b1, 1'b0, 1'b0, 32'hA1, 32'h200);
      apply(1'b1, 1'b0, 1'b0, 32'hA2, 32'h204);
      check("pre_async_rst", dut_out(), {1'b1, 1'b0, 3'd2, 1'b0, 32'hA1, 32'h200});
      #1 rstn = 1'b0;
      #1;
      check("async_rst", dut_out(), {1'b0, 1'b0, 3'd0, 1'b0, NOP, 32'h0});
      m_q.delete(); m_ovf = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      apply(1'b1, 1'b0, 1'b0, 32'hB1, 32'h300);
      check("post_rst_push", dut_out(), {1'b1, 1'b0, 3'd1, 1'b0, 32'hB1, 32'h300});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_ifetch_buf
